// File: rtl/cache_mem_responder.sv
// Word-organised test main memory answering cache refill/evict traffic, one request at a time.
// Optional define CACHE_MEM_RESPONDER_RANDOM_DELAY_EN adds LFSR jitter (0..3 cycles) to the latency.
module cache_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg,
    output logic [1:0]  o_dbg_state
);
    localparam int AW = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: a transfer happens on a rising edge where val && rdy are both high;
    // val never waits on rdy, and rdy never depends combinationally on val.
    state_t         r_state;
    state_t         w_state_next;
    logic [4:0]     r_count;
    logic [4:0]     w_count_load;
    logic [46:0]    r_resp;
    logic [31:0]    r_mem [NUM_WORDS];

    logic [2:0]     w_type;
    logic [7:0]     w_opaque;
    logic [31:0]    w_addr;
    logic [1:0]     w_len;
    logic [31:0]    w_data;
    logic [AW-1:0]  w_idx;
    logic [1:0]     w_off;
    logic           w_accept;
    logic           w_is_write;
    logic [31:0]    w_word;
    logic [31:0]    w_shifted;
    logic [31:0]    w_rdata;
    logic [3:0]     w_base_mask;
    logic [3:0]     w_wmask;
    logic [31:0]    w_wdata;

    assign w_type   = memreq_msg[76:74];
    assign w_opaque = memreq_msg[73:66];
    assign w_addr   = memreq_msg[65:34];
    assign w_len    = memreq_msg[33:32];
    assign w_data   = memreq_msg[31:0];
    assign w_idx    = w_addr[2 +: AW];
    assign w_off    = w_addr[1:0];
    assign w_accept   = memreq_val && memreq_rdy;
    assign w_is_write = (w_type == 3'd1) || (w_type == 3'd2);

`ifdef CACHE_MEM_RESPONDER_RANDOM_DELAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_count_load = 5'(LATENCY) + {3'b000, r_lfsr[1:0]};
`else
    assign w_count_load = 5'(LATENCY);
`endif

    // Read path: bytes beyond lane 3 shift in as zero, giving the zero-extension for free.
    always_comb begin
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_off, 3'b000};
        case (w_len)
            2'd1:    w_rdata = {24'b0, w_shifted[7:0]};
            2'd2:    w_rdata = {16'b0, w_shifted[15:0]};
            2'd3:    w_rdata = {8'b0,  w_shifted[23:0]};
            default: w_rdata = w_word;
        endcase
    end

    // Write lanes: the 4-bit mask truncates on shift, so nothing spills into the next word.
    always_comb begin
        case (w_len)
            2'd1:    w_base_mask = 4'b0001;
            2'd2:    w_base_mask = 4'b0011;
            2'd3:    w_base_mask = 4'b0111;
            default: w_base_mask = 4'b1111;
        endcase
        w_wmask = w_base_mask << w_off;
        w_wdata = w_data << {w_off, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_count_load == 5'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count <= 5'd1) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (memresp_rdy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        memreq_rdy  = (r_state == S_IDLE) && !reset;
        memresp_val = (r_state == S_RESP);
        memresp_msg = r_resp;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 5'd0;
            r_resp  <= 47'd0;
        end else if (w_accept) begin
            r_count <= w_count_load;
            r_resp  <= {w_type, w_opaque, 2'b00, w_len,
                        (w_type == 3'd0) ? w_rdata : 32'd0};
        end else if (r_state == S_WAIT) begin
            r_count <= r_count - 5'd1;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: the driver pushes expected responses,
// a negedge monitor pops and compares every response handshake.
module tb_cache_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [76:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [46:0] memresp_msg;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [46:0] exp_q[$];
    logic [46:0] mon_exp;

    cache_mem_responder #(.NUM_WORDS(256), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && memresp_val && memresp_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected no response", memresp_msg);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_msg", 64'(memresp_msg), 64'(mon_exp));
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d, input logic [31:0] ed,
                        input bit expect_resp, output int acc);
        int n;
        n = 0;
        if (expect_resp) exp_q.push_back({t, op, 2'b00, l, ed});
        memreq_msg = {t, op, a, l, d};
        memreq_val = 1'b1;
        while (!memreq_rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!memreq_rdy) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: memreq_rdy=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        memreq_val = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int  acc;
        int  acc2;
        int  first;
        bit  ok;
        logic [46:0] saved;

        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_rdy", 64'(memreq_rdy), 64'd0);
        check("reset_resp_val", 64'(memresp_val), 64'd0);
        check("reset_resp_msg", 64'(memresp_msg), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_rdy", 64'(memreq_rdy), 64'd1);

        // Init then full-word read with latency and in-flight rdy check.
        send(3'd2, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0, 1'b1, acc);
        wait_drain("drain_init");
        send(3'd0, 8'h5A, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1, acc);
        ok = 1'b1;
        first = -1;
        for (int i = 0; i < 50 && first < 0; i++) begin
            @(negedge clk);
            if (memreq_rdy) ok = 1'b0;
            if (memresp_val) first = cyc;
        end
        // Registered by edge acc+LAT, so sampled high at edge acc+1+LAT.
        check("resp_latency", 64'(first - acc), 64'(LAT));
        check("req_rdy_low_in_flight", 64'(ok), 64'd1);
        wait_drain("drain_read");

        // Byte-lane writes and sub-word reads.
        send(3'd2, 8'h02, 32'h200, 2'd0, 32'h11223344, 32'h0, 1'b1, acc);
        send(3'd1, 8'h03, 32'h202, 2'd1, 32'h000000AB, 32'h0, 1'b1, acc);
        send(3'd0, 8'h04, 32'h200, 2'd0, 32'h0, 32'h11AB3344, 1'b1, acc);
        send(3'd0, 8'h05, 32'h203, 2'd1, 32'h0, 32'h00000011, 1'b1, acc);
        send(3'd0, 8'h06, 32'h201, 2'd2, 32'h0, 32'h0000AB33, 1'b1, acc);
        send(3'd0, 8'h07, 32'h202, 2'd3, 32'h0, 32'h000011AB, 1'b1, acc);
        send(3'd1, 8'h08, 32'h203, 2'd2, 32'h0000CCDD, 32'h0, 1'b1, acc);
        send(3'd0, 8'h09, 32'h200, 2'd0, 32'h0, 32'hDDAB3344, 1'b1, acc);
        wait_drain("drain_bytes");

        // Backpressure: response held stable while rdy is low.
        memresp_rdy = 1'b0;
        send(3'd0, 8'hB7, 32'h200, 2'd0, 32'h0, 32'hDDAB3344, 1'b1, acc);
        first = -1;
        for (int i = 0; i < 50 && first < 0; i++) begin
            @(negedge clk);
            if (memresp_val) first = cyc;
        end
        check("bp_resp_seen", 64'(first >= 0), 64'd1);
        saved = memresp_msg;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!memresp_val || memresp_msg !== saved || memreq_rdy) ok = 1'b0;
        end
        check("bp_hold_stable", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        memresp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_req_rdy", 64'(memreq_rdy), 64'd1);
        check("bp_idle_resp_val", 64'(memresp_val), 64'd0);
        wait_drain("drain_bp");

        // Back-to-back throughput.
        send(3'd0, 8'h21, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1, acc);
        send(3'd0, 8'h22, 32'h203, 2'd1, 32'h0, 32'h000000DD, 1'b1, acc2);
        check("accept_spacing", 64'(acc2 - acc), 64'(LAT + 2));
        wait_drain("drain_tput");

        // Address wrap and unknown type.
        send(3'd1, 8'h31, 32'h400, 2'd0, 32'h00000005, 32'h0, 1'b1, acc);
        send(3'd0, 8'h32, 32'h000, 2'd0, 32'h0, 32'h00000005, 1'b1, acc);
        send(3'd3, 8'h33, 32'h100, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b1, acc);
        send(3'd0, 8'h34, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1, acc);
        wait_drain("drain_wrap");

        // Reset while waiting: response dropped, write kept.
        send(3'd1, 8'h41, 32'h10, 2'd0, 32'h00000077, 32'h0, 1'b0, acc);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_req_rdy", 64'(memreq_rdy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_rdy", 64'(memreq_rdy), 64'd1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (memresp_val) ok = 1'b0;
        end
        check("post_reset_no_resp", 64'(ok), 64'd1);
        send(3'd0, 8'h42, 32'h10, 2'd0, 32'h0, 32'h00000077, 1'b1, acc);
        wait_drain("drain_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
